// File: rtl/breakout_game_sequencer_if.sv
// rtl/breakout_game_sequencer_if.sv - event inputs and game-status outputs of the breakout sequencer
interface breakout_game_sequencer_if;
    logic       tick;
    logic       start;
    logic       block_hit;
    logic       ball_lost;
    logic [2:0] state;
    logic       motion_en;
    logic       grid_reload;
    logic       serve_load;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [3:0] lives;
    logic [1:0] level;
    logic [6:0] blocks_left;

    modport master (
        output tick, start, block_hit, ball_lost,
        input  state, motion_en, grid_reload, serve_load,
        input  score_ones, score_tens, lives, level, blocks_left
    );

    modport slave (
        input  tick, start, block_hit, ball_lost,
        output state, motion_en, grid_reload, serve_load,
        output score_ones, score_tens, lives, level, blocks_left
    );
endinterface

// File: rtl/breakout_game_sequencer.sv
// rtl/breakout_game_sequencer.sv - breakout game-flow FSM: lives, BCD score, blocks, level
// Optional macro EXTRA_LIFE_EN: award a life on every tens-digit increment of the score.
module breakout_game_sequencer #(
    parameter int INIT_LIVES  = 9,
    parameter int NUM_BLOCKS  = 60,
    parameter int SERVE_TICKS = 60,
    parameter int LEVEL_MAX   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    breakout_game_sequencer_if.slave   bus
);
    localparam int TW = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_SERVE     = 3'b001,
        ST_PLAY      = 3'b010,
        ST_LOST      = 3'b011,
        ST_LEVEL_UP  = 3'b100,
        ST_WIN       = 3'b101,
        ST_GAME_OVER = 3'b110
    } state_t;

    state_t          state_q, state_next;
    logic [TW-1:0]   timer_q;
    logic [3:0]      ones_q, tens_q, lives_q, lives_upd;
    logic [1:0]      level_q;
    logic [6:0]      blocks_q;
    logic            motion_q, grid_q, serve_q;
    logic            game_init, level_init, timer_load, timer_dec;
    logic            grid_pulse, serve_pulse;
    logic            in_play, hit_ok, clears, loss_ok, timer_last, score_max;

    assign in_play    = (state_q == ST_PLAY);
    assign hit_ok     = in_play && bus.block_hit;
    assign clears     = hit_ok && (blocks_q == 7'd1);
    // A hit that empties the grid takes priority; a simultaneous loss is dropped.
    assign loss_ok    = in_play && bus.ball_lost && !clears;
    assign timer_last = (timer_q <= TW'(1));
    assign score_max  = (tens_q == 4'd9) && (ones_q == 4'd9);

`ifdef EXTRA_LIFE_EN
    logic bonus;
    assign bonus = hit_ok && (ones_q == 4'd9) && !score_max;

    always_comb begin
        lives_upd = lives_q;
        if (bonus && loss_ok)
            lives_upd = lives_q;
        else if (bonus)
            lives_upd = (lives_q < 4'd9) ? lives_q + 4'd1 : lives_q;
        else if (loss_ok)
            lives_upd = lives_q - 4'd1;
    end
`else
    always_comb begin
        lives_upd = lives_q;
        if (loss_ok)
            lives_upd = lives_q - 4'd1;
    end
`endif

    always_comb begin
        state_next  = state_q;
        game_init   = 1'b0;
        level_init  = 1'b0;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;
        grid_pulse  = 1'b0;
        serve_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next  = ST_SERVE;
                    game_init   = 1'b1;
                    timer_load  = 1'b1;
                    grid_pulse  = 1'b1;
                    serve_pulse = 1'b1;
                end
            end
            ST_SERVE: begin
                if (bus.tick) begin
                    timer_dec = 1'b1;
                    if (timer_last)
                        state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (clears) begin
                    state_next = (level_q < 2'(LEVEL_MAX)) ? ST_LEVEL_UP : ST_WIN;
                end else if (loss_ok) begin
                    if (lives_upd == 4'd0) begin
                        state_next = ST_GAME_OVER;
                    end else begin
                        state_next = ST_LOST;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_LOST: begin
                if (bus.tick) begin
                    timer_dec = 1'b1;
                    if (timer_last) begin
                        state_next  = ST_SERVE;
                        timer_load  = 1'b1;
                        serve_pulse = 1'b1;
                    end
                end
            end
            ST_LEVEL_UP: begin
                state_next  = ST_SERVE;
                level_init  = 1'b1;
                timer_load  = 1'b1;
                grid_pulse  = 1'b1;
                serve_pulse = 1'b1;
            end
            ST_WIN, ST_GAME_OVER: begin
                if (bus.start)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            motion_q <= 1'b0;
            grid_q   <= 1'b0;
            serve_q  <= 1'b0;
            timer_q  <= '0;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            lives_q  <= 4'(INIT_LIVES);
            level_q  <= 2'd1;
            blocks_q <= 7'(NUM_BLOCKS);
        end else begin
            state_q  <= state_next;
            motion_q <= (state_next == ST_PLAY);
            grid_q   <= grid_pulse;
            serve_q  <= serve_pulse;

            if (timer_load)
                timer_q <= TW'(SERVE_TICKS);
            else if (timer_dec && (timer_q != '0))
                timer_q <= timer_q - TW'(1);

            if (game_init) begin
                ones_q   <= 4'd0;
                tens_q   <= 4'd0;
                lives_q  <= 4'(INIT_LIVES);
                level_q  <= 2'd1;
                blocks_q <= 7'(NUM_BLOCKS);
            end else begin
                lives_q <= lives_upd;
                if (level_init) begin
                    level_q  <= level_q + 2'd1;
                    blocks_q <= 7'(NUM_BLOCKS);
                end
                if (hit_ok) begin
                    if (blocks_q != 7'd0)
                        blocks_q <= blocks_q - 7'd1;
                    if (!score_max) begin
                        if (ones_q == 4'd9) begin
                            ones_q <= 4'd0;
                            tens_q <= tens_q + 4'd1;
                        end else begin
                            ones_q <= ones_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.motion_en   = motion_q;
    assign bus.grid_reload = grid_q;
    assign bus.serve_load  = serve_q;
    assign bus.score_ones  = ones_q;
    assign bus.score_tens  = tens_q;
    assign bus.lives       = lives_q;
    assign bus.level       = level_q;
    assign bus.blocks_left = blocks_q;
endmodule

// File: tb/tb_breakout_game_sequencer.sv
// tb/tb_breakout_game_sequencer.sv - randomized directed bench with a game-rules reference model
module tb_breakout_game_sequencer;
    localparam int INIT_LIVES = 9;
    localparam int NB         = 60;
    localparam int ST         = 60;
    localparam int LMAX       = 3;
`ifdef EXTRA_LIFE_EN
    localparam bit EXTRA = 1'b1;
`else
    localparam bit EXTRA = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    breakout_game_sequencer_if bus();

    breakout_game_sequencer #(
        .INIT_LIVES(INIT_LIVES), .NUM_BLOCKS(NB), .SERVE_TICKS(ST), .LEVEL_MAX(LMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: game rules in plain integers (score kept as 0..99).
    int m_state, m_score, m_lives, m_level, m_blocks, m_timer;
    int e_grid, e_serve;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_lives = INIT_LIVES; m_level = 1;
        m_blocks = NB; m_timer = 0; e_grid = 0; e_serve = 0;
    endtask

    task automatic model_step(input bit tk, input bit st, input bit bh, input bit bl);
        bit clear, lose, carry;
        e_grid = 0; e_serve = 0;
        case (m_state)
            0: if (st) begin
                m_state = 1; m_score = 0; m_lives = INIT_LIVES; m_level = 1;
                m_blocks = NB; m_timer = ST; e_grid = 1; e_serve = 1;
            end
            1: if (tk) begin
                m_timer--;
                if (m_timer <= 0) begin m_timer = 0; m_state = 2; end
            end
            2: begin
                clear = bh && (m_blocks == 1);
                lose  = bl && !clear;
                carry = 0;
                if (bh) begin
                    m_blocks--;
                    carry = (m_score % 10 == 9) && (m_score != 99);
                    if (m_score < 99) m_score++;
                end
                if (EXTRA && carry && lose) ;
                else if (EXTRA && carry) begin if (m_lives < 9) m_lives++; end
                else if (lose) m_lives--;
                if (clear) m_state = (m_level < LMAX) ? 4 : 5;
                else if (lose) begin
                    if (m_lives == 0) m_state = 6;
                    else begin m_state = 3; m_timer = ST; end
                end
            end
            3: if (tk) begin
                m_timer--;
                if (m_timer <= 0) begin m_state = 1; m_timer = ST; e_serve = 1; end
            end
            4: begin
                m_level++; m_blocks = NB; m_timer = ST; e_grid = 1; e_serve = 1; m_state = 1;
            end
            5, 6: if (st) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all();
        chk("state",       32'(bus.state),       32'(m_state));
        chk("motion_en",   32'(bus.motion_en),   32'(m_state == 2));
        chk("grid_reload", 32'(bus.grid_reload), 32'(e_grid));
        chk("serve_load",  32'(bus.serve_load),  32'(e_serve));
        chk("score_tens",  32'(bus.score_tens),  32'(m_score / 10));
        chk("score_ones",  32'(bus.score_ones),  32'(m_score % 10));
        chk("lives",       32'(bus.lives),       32'(m_lives));
        chk("level",       32'(bus.level),       32'(m_level));
        chk("blocks_left", 32'(bus.blocks_left), 32'(m_blocks));
    endtask

    task automatic cyc(input bit r, input bit tk, input bit st, input bit bh, input bit bl);
        rst = r; bus.tick = tk; bus.start = st; bus.block_hit = bh; bus.ball_lost = bl;
        @(posedge clk);
        if (r) model_reset();
        else model_step(tk, st, bh, bl);
        #1;
        check_all();
    endtask

    // Hold events off (noise only where it must be ignored) until the model reaches a state.
    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (m_state != target && n < budget) begin
            cyc(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1));
            n++;
        end
        chk("run_until_state", 32'(bus.state), 32'(target));
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) cyc(0, $urandom_range(0, 1), 0, 1, 0);
    endtask

    initial begin
        bus.tick = 0; bus.start = 0; bus.block_hit = 0; bus.ball_lost = 0;
        model_reset();

        // reset state and first serve
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        cyc(0, 1, 1, 0, 0);
        chk("start_grid", 32'(bus.grid_reload), 1);
        cyc(0, 0, 0, 0, 0);
        chk("start_grid_once", 32'(bus.grid_reload), 0);
        run_until(2, 400);
        chk("play_motion", 32'(bus.motion_en), 1);

        // twelve hits from a fresh game
        hits(12);
        chk("score12_tens", 32'(bus.score_tens), 1);
        chk("score12_ones", 32'(bus.score_ones), 2);
        chk("blocks48", 32'(bus.blocks_left), 48);

        // free-running random play
        for (int i = 0; i < 600; i++)
            cyc(0, $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));

        // lose every life
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        run_until(2, 400);
        for (int i = 0; i < INIT_LIVES; i++) begin
            cyc(0, $urandom_range(0, 1), 0, 0, 1);
            if (i < INIT_LIVES - 1) run_until(2, 600);
        end
        chk("gameover_state", 32'(bus.state), 6);
        chk("gameover_lives", 32'(bus.lives), 0);
        chk("gameover_motion", 32'(bus.motion_en), 0);
        cyc(0, 1, 0, 1, 1);
        chk("gameover_frozen", 32'(bus.lives), 0);
        cyc(0, 0, 1, 0, 0);
        chk("to_idle", 32'(bus.state), 0);
        cyc(0, 0, 1, 0, 0);
        chk("restart_serve", 32'(bus.state), 1);
        chk("restart_lives", 32'(bus.lives), INIT_LIVES);

        // last block hit together with a loss
        run_until(2, 400);
        hits(NB - 1);
        chk("one_left", 32'(bus.blocks_left), 1);
        cyc(0, 0, 0, 1, 1);
        chk("lvlup_state", 32'(bus.state), 4);
        cyc(0, 0, 0, 0, 0);
        chk("lvlup_serve", 32'(bus.state), 1);
        chk("lvlup_level", 32'(bus.level), 2);
        chk("lvlup_lives", 32'(bus.lives), INIT_LIVES);
        chk("lvlup_blocks", 32'(bus.blocks_left), NB);
        chk("lvlup_grid", 32'(bus.grid_reload), 1);

        // score saturation and win
        run_until(2, 400);
        hits(NB);
        chk("sat_tens", 32'(bus.score_tens), 9);
        chk("sat_ones", 32'(bus.score_ones), 9);
        run_until(2, 400);
        hits(NB);
        chk("win_state", 32'(bus.state), 5);
        hits(5);
        chk("win_score", 32'(bus.score_ones), 9);
        chk("win_blocks", 32'(bus.blocks_left), 0);
        cyc(0, 0, 1, 0, 0);
        chk("win_idle", 32'(bus.state), 0);

        // reset while the loss timer is half way
        cyc(0, 0, 1, 0, 0);
        run_until(2, 400);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < ST / 2; i++) cyc(0, 1, 0, 0, 0);
        chk("mid_lost", 32'(bus.state), 3);
        cyc(1, 1, 1, 1, 1);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_serve", 32'(bus.serve_load), 0);
        chk("rst_lives", 32'(bus.lives), INIT_LIVES);
        cyc(0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
